// File: rtl/fpu_mul_stg1_issue_if.sv
// Handshake and stage-1 operand bundle between the FPU multiply front end and its neighbours.
// The slave modport is the issue block; the master modport is the upstream/downstream side.
interface fpu_mul_stg1_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  A_exp_1;
    logic [22:0] A_frac_1;
    logic [7:0]  B_exp_1;
    logic [22:0] B_frac_1;
    logic        sign_1;
    logic        primal_1;
    logic [7:0]  primal_exp_1;
    logic [22:0] primal_frac_1;
    logic        error_1;
    logic [1:0]  count;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, A_exp_1, A_frac_1, B_exp_1, B_frac_1,
               sign_1, primal_1, primal_exp_1, primal_frac_1, error_1, count
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, A_exp_1, A_frac_1, B_exp_1, B_frac_1,
               sign_1, primal_1, primal_exp_1, primal_frac_1, error_1, count
    );
endinterface

// File: rtl/fpu_mul_stg1_issue.sv
// FPU multiply stage-1 issue: unpacks/classifies operand pairs into a 2-entry skid buffer.
// Optional flush-to-zero of denormal operands when FPU_STG1_DENORM_FLUSH_EN is defined.
module fpu_mul_stg1_issue #(
    parameter logic [22:0] QNAN_FRAC = 23'h400000,
    parameter int          DEPTH     = 2
) (
    input logic                      clk,
    input logic                      nRESET,
    input logic                      flush,
    fpu_mul_stg1_issue_if.slave      bus
);
    localparam int PtrW = $clog2(DEPTH);

    typedef struct packed {
        logic [7:0]  a_exp;
        logic [22:0] a_frac;
        logic [7:0]  b_exp;
        logic [22:0] b_frac;
        logic        sign;
        logic        primal;
        logic [7:0]  p_exp;
        logic [22:0] p_frac;
        logic        error;
    } entry_t;

    // Handshake: a push happens on in_valid && in_ready, a pop on out_valid && out_ready;
    // both ready and valid come straight from the registered count.
    function automatic entry_t classify(input logic [31:0] a, input logic [31:0] b);
        entry_t e;
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        e        = '0;
        e.a_exp  = a[30:23];
        e.a_frac = a[22:0];
        e.b_exp  = b[30:23];
        e.b_frac = b[22:0];
        e.sign   = a[31] ^ b[31];
        a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf    = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf    = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
`ifdef FPU_STG1_DENORM_FLUSH_EN
        // Denormals count as zero and lose their fraction before leaving this stage.
        a_zero   = (a[30:23] == 8'h00);
        b_zero   = (b[30:23] == 8'h00);
        if (a_zero) e.a_frac = 23'd0;
        if (b_zero) e.b_frac = 23'd0;
`else
        a_zero   = (a[30:23] == 8'h00) && (a[22:0] == 23'd0);
        b_zero   = (b[30:23] == 8'h00) && (b[22:0] == 23'd0);
`endif
        if (a_nan || b_nan || ((a_inf || b_inf) && (a_zero || b_zero))) begin
            e.primal = 1'b1;
            e.error  = 1'b1;
            e.p_exp  = 8'hFF;
            e.p_frac = QNAN_FRAC;
        end else if (a_inf || b_inf) begin
            e.primal = 1'b1;
            e.p_exp  = 8'hFF;
        end else if (a_zero || b_zero) begin
            e.primal = 1'b1;
        end
        return e;
    endfunction

    entry_t            mem_q [DEPTH];
    entry_t            last_q;
    entry_t            head;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic              push, pop;

    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= classify(bus.in_a, bus.in_b);
    end

    // last_q keeps the most recently popped entry so an empty buffer shows stable values.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            count_q  <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else if (flush) begin
            count_q  <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
        end
    end

    assign head = (count_q != 2'd0) ? mem_q[rd_ptr_q] : last_q;

    assign bus.A_exp_1       = head.a_exp;
    assign bus.A_frac_1      = head.a_frac;
    assign bus.B_exp_1       = head.b_exp;
    assign bus.B_frac_1      = head.b_frac;
    assign bus.sign_1        = head.sign;
    assign bus.primal_1      = head.primal;
    assign bus.primal_exp_1  = head.p_exp;
    assign bus.primal_frac_1 = head.p_frac;
    assign bus.error_1       = head.error;
    assign bus.count         = count_q;
endmodule

// File: tb/tb_fpu_mul_stg1_issue.sv
// Directed bench for fpu_mul_stg1_issue: classification vector table plus
// back-pressure, streaming, flush and asynchronous reset sequences.
module tb_fpu_mul_stg1_issue;
  logic clk;
  logic nRESET;
  logic flush;
  int   n_checks;
  int   n_errors;
  logic [7:0] exp_q[$];

  fpu_mul_stg1_issue_if bus ();

  fpu_mul_stg1_issue dut (
    .clk    (clk),
    .nRESET (nRESET),
    .flush  (flush),
    .bus    (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [95:0] exp_bundle; // {A_exp,A_frac,B_exp,B_frac,sign,primal,p_exp,p_frac,error}
  } vec_t;

  vec_t vecs[9];

  function automatic logic [95:0] mk(input logic [7:0] ae, input logic [22:0] af,
                                     input logic [7:0] be, input logic [22:0] bf,
                                     input logic s, input logic p, input logic [7:0] pe,
                                     input logic [22:0] pf, input logic er);
    return {ae, af, be, bf, s, p, pe, pf, er};
  endfunction

  function automatic logic [95:0] got_bundle();
    return {bus.A_exp_1, bus.A_frac_1, bus.B_exp_1, bus.B_frac_1, bus.sign_1,
            bus.primal_1, bus.primal_exp_1, bus.primal_frac_1, bus.error_1};
  endfunction

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic rdy);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{"one_x_two",  32'h3F800000, 32'h40000000, mk(8'h7F, 23'h0, 8'h80, 23'h0, 1'b0, 1'b0, 8'h00, 23'h0, 1'b0)};
    vecs[1] = '{"inf_x_zero", 32'h7F800000, 32'h00000000, mk(8'hFF, 23'h0, 8'h00, 23'h0, 1'b0, 1'b1, 8'hFF, 23'h400000, 1'b1)};
    vecs[2] = '{"ninf_x_one", 32'hFF800000, 32'h3F800000, mk(8'hFF, 23'h0, 8'h7F, 23'h0, 1'b1, 1'b1, 8'hFF, 23'h0, 1'b0)};
    vecs[3] = '{"nan_x_one",  32'h7FC00001, 32'h3F800000, mk(8'hFF, 23'h400001, 8'h7F, 23'h0, 1'b0, 1'b1, 8'hFF, 23'h400000, 1'b1)};
    vecs[4] = '{"nzero_x_m3", 32'h80000000, 32'hC0400000, mk(8'h00, 23'h0, 8'h80, 23'h400000, 1'b0, 1'b1, 8'h00, 23'h0, 1'b0)};
`ifdef FPU_STG1_DENORM_FLUSH_EN
    vecs[5] = '{"denorm_x_one", 32'h00000001, 32'h3F800000, mk(8'h00, 23'h0, 8'h7F, 23'h0, 1'b0, 1'b1, 8'h00, 23'h0, 1'b0)};
`else
    vecs[5] = '{"denorm_x_one", 32'h00000001, 32'h3F800000, mk(8'h00, 23'h1, 8'h7F, 23'h0, 1'b0, 1'b0, 8'h00, 23'h0, 1'b0)};
`endif
    vecs[6] = '{"inf_x_nan",  32'h7F800000, 32'h7F800001, mk(8'hFF, 23'h0, 8'hFF, 23'h1, 1'b0, 1'b1, 8'hFF, 23'h400000, 1'b1)};
    vecs[7] = '{"m5_x_3",     32'hC0A00000, 32'h40400000, mk(8'h81, 23'h200000, 8'h80, 23'h400000, 1'b1, 1'b0, 8'h00, 23'h0, 1'b0)};
    vecs[8] = '{"zero_x_ninf", 32'h00000000, 32'hFF800000, mk(8'h00, 23'h0, 8'hFF, 23'h0, 1'b1, 1'b1, 8'hFF, 23'h400000, 1'b1)};

    nRESET = 1'b0;
    flush  = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #12;
    check("reset_count", 96'(bus.count), 96'(0));
    check("reset_handshake", 96'({bus.out_valid, bus.in_ready}), 96'(2'b01));
    check("reset_bundle", got_bundle(), 96'(0));
    @(negedge clk);
    nRESET = 1'b1;
    @(negedge clk);

    // classification table: push, check head next cycle, pop
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, 1'b1);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      check({vecs[i].name, "_valid"}, 96'(bus.out_valid), 96'(1));
      check(vecs[i].name, got_bundle(), vecs[i].exp_bundle);
      step();
      check({vecs[i].name, "_drained"}, 96'(bus.count), 96'(0));
    end

    // back-pressure: three back-to-back offers, only two accepted
    drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
    step();
    check("bp_count1", 96'(bus.count), 96'(1));
    drive(1'b1, 32'h40000000, 32'h3F800000, 1'b0);
    step();
    check("bp_count2", 96'({bus.count, bus.in_ready}), 96'({2'd2, 1'b0}));
    drive(1'b1, 32'h40800000, 32'h3F800000, 1'b0);
    step();
    check("bp_third_rejected", 96'(bus.count), 96'(2));
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    check("bp_head0", 96'(bus.A_exp_1), 96'(8'h7F));
    step();
    check("bp_head1", 96'({bus.count, bus.A_exp_1}), 96'({2'd1, 8'h80}));
    step();
    check("bp_empty", 96'({bus.count, bus.in_ready, bus.out_valid}), 96'({2'd0, 1'b1, 1'b0}));

    // streaming at count=1 with simultaneous push and pop
    exp_q.delete();
    drive(1'b1, 32'h3F000000, 32'h3F800000, 1'b0);
    exp_q.push_back(8'h7E);
    step();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = 8'h10 + 8'(i);
      drive(1'b1, {1'b0, e, 23'h0}, 32'h3F800000, 1'b1);
      check("stream_head", 96'({bus.count, bus.A_exp_1}), 96'({2'd1, exp_q[0]}));
      void'(exp_q.pop_front());
      exp_q.push_back(e);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    check("stream_last", 96'({bus.count, bus.A_exp_1}), 96'({2'd1, exp_q[0]}));
    void'(exp_q.pop_front());
    step();
    check("stream_empty", 96'(bus.count), 96'(0));

    // flush at count=2 with a concurrent push offer
    drive(1'b1, 32'h3F800000, 32'h40000000, 1'b0);
    step();
    step();
    check("flush_prefill", 96'(bus.count), 96'(2));
    flush = 1'b1;
    drive(1'b1, 32'h40800000, 32'h40000000, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    check("flush_state", 96'({bus.count, bus.out_valid, bus.in_ready}), 96'({2'd0, 1'b0, 1'b1}));
    check("flush_bundle", got_bundle(), 96'(0));
    step();
    check("flush_no_emit", 96'({bus.count, bus.out_valid}), 96'(0));

    // asynchronous reset mid-stream
    drive(1'b1, 32'hC0A00000, 32'h40400000, 1'b0);
    step();
    check("rst_prefill", 96'(bus.count), 96'(1));
    #2;
    nRESET = 1'b0;
    #1;
    check("rst_async_state", 96'({bus.count, bus.out_valid, bus.in_ready}), 96'({2'd0, 1'b0, 1'b1}));
    check("rst_async_bundle", got_bundle(), 96'(0));
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    nRESET = 1'b1;
    step();
    check("rst_stays_empty", 96'({bus.count, bus.out_valid}), 96'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
